issue_select: RTL and testbench

- Consumes the per-functional-unit dependency matrix's ready vector.
- Each cycle, picks the oldest ready reservation-station entry and holds it in a one-entry issue register that feeds the FU through a valid/ready handshake.
- On FU acceptance, frees the matrix row and broadcasts the wakeup clear for dependents.
- Tracks entry age with an internal age matrix that is updated on every allocation.

---
 rtl/issue_select.sv | 153 +++++++++++++++
 tb/tb_issue_select.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_select.sv
// Oldest-ready pick for one FU's reservation station, with a one-entry issue register and row release on accept.
// Optional perf counters are built when ISSUE_SELECT_PERF_EN is defined.
module issue_select #(
  parameter int NUM_ROWS = 8,
  localparam int IDX_W = $clog2(NUM_ROWS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_ROWS-1:0] ready_vector,
  input  logic                alloc_en,
  input  logic [IDX_W-1:0]    alloc_row_index,
  input  logic                flush,
  input  logic                issue_ready,
  output logic                issue_valid,
  output logic [IDX_W-1:0]    issue_row_index,
  output logic                free_en,
  output logic [IDX_W-1:0]    free_row_index,
  output logic                clear_en,
  output logic [NUM_ROWS-1:0] clear_lines
`ifdef ISSUE_SELECT_PERF_EN
  ,
  output logic [31:0]         perf_issue_count,
  output logic [31:0]         perf_stall_count
`endif
);

  localparam logic [NUM_ROWS-1:0] ONE_HOT_BASE = {{(NUM_ROWS-1){1'b0}}, 1'b1};

  logic [NUM_ROWS-1:0] older_r     [NUM_ROWS];
  logic [NUM_ROWS-1:0] older_nxt_s [NUM_ROWS];
  logic [NUM_ROWS-1:0] tracked_r;
  logic [NUM_ROWS-1:0] tracked_nxt_s;
  logic [NUM_ROWS-1:0] inflight_s;
  logic [NUM_ROWS-1:0] cand_s;
  logic [NUM_ROWS-1:0] free_mask_s;
  logic [NUM_ROWS-1:0] blocked_s;
  logic [IDX_W-1:0]    pick_s;
  logic                accept_s;

  // Candidate masking and oldest-ready pick; the row in the register is masked so it is never reselected.
  always_comb begin
    inflight_s = {NUM_ROWS{1'b0}};
    if (issue_valid) begin
      inflight_s = ONE_HOT_BASE << issue_row_index;
    end else begin
      inflight_s = {NUM_ROWS{1'b0}};
    end
    cand_s    = ready_vector & ~inflight_s;
    blocked_s = {NUM_ROWS{1'b0}};
    pick_s    = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_ROWS; i++) begin
      for (int j = 0; j < NUM_ROWS; j++) begin
        if (cand_s[j] && older_r[j][i]) begin
          blocked_s[i] = 1'b1;
        end else begin
          blocked_s[i] = blocked_s[i];
        end
      end
      if (cand_s[i] && !blocked_s[i]) begin
        pick_s = IDX_W'(i);
      end else begin
        pick_s = pick_s;
      end
    end
  end

  // A flush suppresses the release pulse even when the FU is ready.
  assign accept_s       = issue_valid & issue_ready & ~flush;
  assign free_mask_s    = accept_s ? inflight_s : {NUM_ROWS{1'b0}};
  assign free_en        = accept_s;
  assign free_row_index = issue_row_index;
  assign clear_en       = accept_s;
  assign clear_lines    = free_mask_s;

  // Next tracked-valid set and age matrix: a new row is younger than every row still tracked after this cycle's free.
  always_comb begin
    tracked_nxt_s = tracked_r & ~free_mask_s;
    older_nxt_s   = older_r;
    if (alloc_en) begin
      tracked_nxt_s = tracked_nxt_s | (ONE_HOT_BASE << alloc_row_index);
      for (int k = 0; k < NUM_ROWS; k++) begin
        older_nxt_s[k][alloc_row_index] = tracked_r[k] & ~free_mask_s[k];
      end
      older_nxt_s[alloc_row_index] = {NUM_ROWS{1'b0}};
    end else begin
      tracked_nxt_s = tracked_nxt_s;
    end
  end

  // Age and tracked-valid state; flush forgets all ordering and wins over a same-cycle alloc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tracked_r <= {NUM_ROWS{1'b0}};
      older_r   <= '{default: {NUM_ROWS{1'b0}}};
    end else if (flush) begin
      tracked_r <= {NUM_ROWS{1'b0}};
      older_r   <= '{default: {NUM_ROWS{1'b0}}};
    end else begin
      tracked_r <= tracked_nxt_s;
      older_r   <= older_nxt_s;
    end
  end

  // One-entry issue register: holds while stalled, refills on empty or accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid     <= 1'b0;
      issue_row_index <= {IDX_W{1'b0}};
    end else if (flush) begin
      issue_valid <= 1'b0;
    end else if (!issue_valid || accept_s) begin
      if (|cand_s) begin
        issue_valid     <= 1'b1;
        issue_row_index <= pick_s;
      end else begin
        issue_valid <= 1'b0;
      end
    end else begin
      issue_valid <= issue_valid;
    end
  end

`ifdef ISSUE_SELECT_PERF_EN
  // Saturating issue/stall counters; only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issue_count <= 32'd0;
      perf_stall_count <= 32'd0;
    end else begin
      if (accept_s && (perf_issue_count != 32'hFFFF_FFFF)) begin
        perf_issue_count <= perf_issue_count + 32'd1;
      end else begin
        perf_issue_count <= perf_issue_count;
      end
      if (issue_valid && !issue_ready && (perf_stall_count != 32'hFFFF_FFFF)) begin
        perf_stall_count <= perf_stall_count + 32'd1;
      end else begin
        perf_stall_count <= perf_stall_count;
      end
    end
  end
`endif

  // Reusing a row that is still held or being released would corrupt the age order.
  a_alloc_not_freed : assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_en && !flush && free_en) |-> (alloc_row_index != free_row_index))
    else $fatal(1, "issue_select: alloc of the row being freed");

  a_alloc_not_inflight : assert property (@(posedge clk) disable iff (!rst_n)
    (alloc_en && !flush && issue_valid) |-> (alloc_row_index != issue_row_index))
    else $fatal(1, "issue_select: alloc of the row held in the issue register");

endmodule

// File: tb/tb_issue_select.sv
// Table-driven directed sequences plus randomized traffic checked against an allocation-order queue model.
module tb_issue_select;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ready_vector;
  logic       alloc_en;
  logic [2:0] alloc_row_index;
  logic       flush;
  logic       issue_ready;
  logic       issue_valid;
  logic [2:0] issue_row_index;
  logic       free_en;
  logic [2:0] free_row_index;
  logic       clear_en;
  logic [7:0] clear_lines;
`ifdef ISSUE_SELECT_PERF_EN
  logic [31:0] perf_issue_count;
  logic [31:0] perf_stall_count;
`endif

  issue_select #(.NUM_ROWS(8)) dut (
    .clk(clk), .rst_n(rst_n), .ready_vector(ready_vector), .alloc_en(alloc_en),
    .alloc_row_index(alloc_row_index), .flush(flush), .issue_ready(issue_ready),
    .issue_valid(issue_valid), .issue_row_index(issue_row_index),
    .free_en(free_en), .free_row_index(free_row_index),
    .clear_en(clear_en),
`ifdef ISSUE_SELECT_PERF_EN
    .perf_issue_count(perf_issue_count), .perf_stall_count(perf_stall_count),
`endif
    .clear_lines(clear_lines)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       s_free, s_clear_en, s_valid;
  logic [2:0] s_frow, s_row;
  logic [7:0] s_clr;

  typedef struct {
    logic       ae;
    logic [2:0] ar;
    logic [7:0] rv;
    logic       fl;
    logic       ir;
    logic       e_free;
    logic [2:0] e_frow;
    logic [7:0] e_clr;
    logic       e_valid;
    logic [2:0] e_row;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ae, logic [2:0] ar, logic [7:0] rv, logic fl, logic ir,
                              logic e_free, logic [2:0] e_frow, logic [7:0] e_clr,
                              logic e_valid, logic [2:0] e_row);
    vec_t v;
    v.ae = ae; v.ar = ar; v.rv = rv; v.fl = fl; v.ir = ir;
    v.e_free = e_free; v.e_frow = e_frow; v.e_clr = e_clr;
    v.e_valid = e_valid; v.e_row = e_row;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: drive at negedge, sample release outputs mid-low-phase, sample register after the edge.
  task automatic cyc(input logic ae, input logic [2:0] ar, input logic [7:0] rv,
                     input logic fl, input logic ir);
    @(negedge clk);
    alloc_en = ae; alloc_row_index = ar; ready_vector = rv; flush = fl; issue_ready = ir;
    #1;
    s_free = free_en; s_frow = free_row_index; s_clear_en = clear_en; s_clr = clear_lines;
    @(posedge clk);
    #1;
    s_valid = issue_valid; s_row = issue_row_index;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0; alloc_en = 1'b0; alloc_row_index = 3'd0; ready_vector = 8'h00;
    flush = 1'b0; issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model: rows in allocation order; the oldest candidate is the first one found in the queue.
  bit       m_valid;
  int       m_row;
  int       q[$];
  bit [7:0] tset;

  function automatic int oldest(input bit [7:0] cand);
    foreach (q[i]) if (cand[q[i]]) return q[i];
    return -1;
  endfunction

  initial begin
    logic [7:0] one8;
    one8 = 8'd1;
    rst_n = 1'b0; alloc_en = 1'b0; alloc_row_index = 3'd0; ready_vector = 8'h00;
    flush = 1'b0; issue_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("reset_issue_row", {29'd0, issue_row_index}, 32'd0);
    chk("reset_free_en", {31'd0, free_en}, 32'd0);
    chk("reset_free_row", {29'd0, free_row_index}, 32'd0);
    chk("reset_clear_en", {31'd0, clear_en}, 32'd0);
    chk("reset_clear_lines", {24'd0, clear_lines}, 32'd0);
`ifdef ISSUE_SELECT_PERF_EN
    chk("reset_perf_issue", perf_issue_count, 32'd0);
    chk("reset_perf_stall", perf_stall_count, 32'd0);
`endif
    rst_n = 1'b1;

    // ae ar rv fl ir | free frow clr | valid row
    tbl.push_back(mk(1'b1, 3'd5, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd2, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd7, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'hA4, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5));
    tbl.push_back(mk(1'b0, 3'd0, 8'hA4, 1'b0, 1'b1, 1'b1, 3'd5, 8'h20, 1'b1, 3'd2));
    tbl.push_back(mk(1'b0, 3'd0, 8'h84, 1'b0, 1'b1, 1'b1, 3'd2, 8'h04, 1'b1, 3'd7));
    tbl.push_back(mk(1'b0, 3'd0, 8'h80, 1'b0, 1'b1, 1'b1, 3'd7, 8'h80, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1'b0, 3'd0, 8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3));
    tbl.push_back(mk(1'b0, 3'd0, 8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd1, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h03, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h03, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 1'b1, 3'd1));
    tbl.push_back(mk(1'b0, 3'd0, 8'h02, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h10, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4));
    tbl.push_back(mk(1'b0, 3'd0, 8'h10, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b1, 3'd6, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h40, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6));
    tbl.push_back(mk(1'b0, 3'd0, 8'h40, 1'b0, 1'b1, 1'b1, 3'd6, 8'h40, 1'b0, 3'd0));
    tbl.push_back(mk(1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0));

    foreach (tbl[i]) begin
      cyc(tbl[i].ae, tbl[i].ar, tbl[i].rv, tbl[i].fl, tbl[i].ir);
      chk($sformatf("tbl%0d_free_en", i), {31'd0, s_free}, {31'd0, tbl[i].e_free});
      chk($sformatf("tbl%0d_clear_en", i), {31'd0, s_clear_en}, {31'd0, tbl[i].e_free});
      chk($sformatf("tbl%0d_clear_lines", i), {24'd0, s_clr}, {24'd0, tbl[i].e_clr});
      if (tbl[i].e_free)
        chk($sformatf("tbl%0d_free_row", i), {29'd0, s_frow}, {29'd0, tbl[i].e_frow});
      chk($sformatf("tbl%0d_issue_valid", i), {31'd0, s_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid)
        chk($sformatf("tbl%0d_issue_row", i), {29'd0, s_row}, {29'd0, tbl[i].e_row});
    end

    // Asynchronous reset in the middle of an accept cycle.
    cyc(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 8'h04, 1'b0, 1'b0);
    chk("arst_setup_valid", {31'd0, s_valid}, 32'd1);
    @(negedge clk);
    issue_ready = 1'b1;
    #1;
    chk("arst_pre_free_en", {31'd0, free_en}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_issue_valid", {31'd0, issue_valid}, 32'd0);
    chk("arst_free_en", {31'd0, free_en}, 32'd0);
    chk("arst_clear_en", {31'd0, clear_en}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; ready_vector = 8'h00;
    cyc(1'b1, 3'd1, 8'h00, 1'b0, 1'b1);
    chk("arst_after_idle", {31'd0, s_valid}, 32'd0);
    cyc(1'b0, 3'd0, 8'h02, 1'b0, 1'b1);
    chk("arst_after_valid", {31'd0, s_valid}, 32'd1);
    chk("arst_after_row", {29'd0, s_row}, 32'd1);
    cyc(1'b0, 3'd0, 8'h02, 1'b0, 1'b1);
    chk("arst_after_free", {31'd0, s_free}, 32'd1);
    cyc(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);

`ifdef ISSUE_SELECT_PERF_EN
    do_reset();
    cyc(1'b1, 3'd0, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 3'd1, 8'h00, 1'b0, 1'b0);
    cyc(1'b1, 3'd2, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 8'h07, 1'b0, 1'b0);
    cyc(1'b0, 3'd0, 8'h07, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 8'h06, 1'b0, 1'b1);
    cyc(1'b0, 3'd0, 8'h04, 1'b0, 1'b1);
    chk("perf_issue", perf_issue_count, 32'd3);
    chk("perf_stall", perf_stall_count, 32'd2);
    cyc(1'b0, 3'd0, 8'h00, 1'b1, 1'b1);
    chk("perf_issue_flush", perf_issue_count, 32'd3);
    chk("perf_stall_flush", perf_stall_count, 32'd2);
`endif

    // Randomized traffic against the queue model.
    do_reset();
    m_valid = 1'b0; m_row = 0; q.delete(); tset = 8'h00;
    for (int n = 0; n < 3000; n++) begin
      logic       fl, ir, ae, acc;
      logic [2:0] ar;
      logic [7:0] rv, cand;
      int         old, p;
      fl = ($urandom_range(0, 63) == 0);
      ir = ($urandom_range(0, 3) != 0);
      ae = 1'b0; ar = 3'd0;
      if (tset != 8'hFF && $urandom_range(0, 1) == 1) begin
        int r;
        r = $urandom_range(0, 7);
        while (tset[r]) r = (r + 1) % 8;
        ae = 1'b1; ar = 3'(r);
      end
      rv = tset & 8'($urandom());
      acc = m_valid && ir && !fl;
      cyc(ae, ar, rv, fl, ir);
      chk("rnd_free_en", {31'd0, s_free}, {31'd0, acc});
      chk("rnd_clear_en", {31'd0, s_clear_en}, {31'd0, acc});
      chk("rnd_clear_lines", {24'd0, s_clr}, {24'd0, (acc ? (one8 << m_row) : 8'h00)});
      if (acc) chk("rnd_free_row", {29'd0, s_frow}, 32'(m_row));
      if (fl) begin
        m_valid = 1'b0; q.delete(); tset = 8'h00;
      end else begin
        old = m_row;
        cand = rv & ~(m_valid ? (one8 << m_row) : 8'h00);
        if (!m_valid || acc) begin
          p = oldest(cand);
          if (p >= 0) begin m_valid = 1'b1; m_row = p; end
          else m_valid = 1'b0;
        end
        if (acc) begin
          tset[old] = 1'b0;
          foreach (q[i]) if (q[i] == old) begin q.delete(i); break; end
        end
        if (ae) begin
          q.push_back(int'(ar)); tset[ar] = 1'b1;
        end
      end
      chk("rnd_issue_valid", {31'd0, s_valid}, {31'd0, m_valid});
      if (m_valid) chk("rnd_issue_row", {29'd0, s_row}, 32'(m_row));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
